recv_store: RTL and testbench
=============================

Name: recv_store

Overview:
- Receive-side counterpart of the senone sender: takes number batches from the uart receiver (rx_nums, rx_available) and writes them word by word into SRAM.
- Sits between uart and the SRAM controller; loads feature vectors from the host into SRAM before decoding.
- Armed by start_recv; stores N_FRAMES batches of N_NUMS numbers at consecutive addresses, then pulses recv_done.

Parameters:
- N_NUMS, 10, numbers per uart batch (must match uart n_rx_nums), >=1
- N_FRAMES, 4, batches stored per start_recv, >=1
- BASE_ADDR, 21'h0, SRAM address of the first stored word

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_recv  in  1  one-cycle pulse; arms block; ignored unless IDLE
- rx_available  in  1  one-cycle pulse from uart; rx_nums valid this cycle
- rx_nums  in  num[N_NUMS-1:0]  received batch, signed 16-bit; index 0 = first number received
- sram_ready  in  1  SRAM controller can accept a write
- write_data  out  1  one-cycle write strobe
- sram_addr  out  21  write address, valid while write_data=1
- data_out  out  num  write data, valid while write_data=1
- busy  out  1  high in every state except IDLE
- recv_done  out  1  one-cycle pulse after the last write of the last frame
- overrun  out  1  sticky flag: a batch arrived while the previous one was still being written

Behaviour:
- Reset values: write_data=0, sram_addr=BASE_ADDR, data_out=0, busy=0, recv_done=0, overrun=0, state=IDLE, idx=0, frame=0. All outputs are registered.
- States: IDLE, ARMED, WRITE, HOLD, DONE.
- IDLE:
  - start_recv=1 -> ARMED.
  - On entry to ARMED: clear overrun, frame=0, addr=BASE_ADDR.
- ARMED:
  - rx_available=1 -> latch all N_NUMS values into an internal buffer, idx=0, -> WRITE.
  - start_recv is ignored.
- WRITE: stalls while sram_ready=0. When sram_ready=1 at a clock edge:
  - next cycle: write_data=1, data_out=buf[idx], sram_addr=addr;
  - addr++, idx++, -> HOLD.
- HOLD: lasts exactly one cycle, with write_data=1 and sram_ready ignored. Next state:
  - idx<N_NUMS -> WRITE;
  - idx==N_NUMS and frame<N_FRAMES-1 -> frame++, ARMED;
  - idx==N_NUMS and frame==N_FRAMES-1 -> DONE.
- DONE: recv_done=1 for one cycle, then IDLE.
- Strobe spacing: write_data is high for exactly one cycle per word, and consecutive strobes are separated by at least one low cycle. Minimum 2 cycles per word.
- Address rule: word k of frame f is written to BASE_ADDR + f*N_NUMS + k. The 21-bit address wraps modulo 2^21, with no error.
- Data is stored unmodified: signed 16-bit, no scaling.
- rx_available in WRITE or HOLD:
  - overrun<=1 and the new batch is dropped; the current batch completes untouched.
  - overrun stays set until the next IDLE->ARMED transition or reset.
- rx_available in IDLE or DONE: ignored; overrun is not set.
- rx_available in the same cycle the block enters ARMED from HOLD: not captured. It counts as an overrun, because the state is HOLD at that edge.
- Reset mid-operation: returns immediately to IDLE with reset values. Words already written are not undone, and the pending buffer is discarded.
- sram_ready held low indefinitely: the block waits in WRITE; there is no timeout.

Test Plan:
1. N_NUMS=10, N_FRAMES=1, BASE_ADDR=0. Drive start_recv pulse, then rx_available with rx_nums[k]=16'h1000+k, sram_ready=1.
   -> 10 write_data pulses, 2 cycles apart; addr 0..9; data 1000..1009; recv_done pulses 2 cycles after the last strobe; busy then falls.
2. N_FRAMES=4, BASE_ADDR=21'h100. Send four batches; batch f holds values f*16+k, including negative 16'h8000.
   -> 40 writes at 0x100..0x127 in order; data bit-exact; exactly one recv_done.
3. Stall: drive sram_ready=0 for 7 cycles before word 3, and low again during HOLD.
   -> no strobe while ready=0; the HOLD-cycle value has no effect; all 10 words still written once each, in order.
4. Overrun: second rx_available arrives while word 5 is being written.
   -> overrun=1; first batch completes at the correct addresses; second batch not written; block returns to ARMED for the next frame; overrun clears on the next start_recv.
5. Reset asserted during WRITE at word 4.
   -> next cycle all outputs are at reset values and state is IDLE; a following start_recv plus batch restarts writing at BASE_ADDR.
6. BASE_ADDR=21'h1FFFFC, N_NUMS=10.
   -> addresses 1FFFFC..1FFFFF, then 0..5; start_recv pulsed while busy has no effect.

Source files
------------

// File: rtl/recv_store.sv
// Collects N_FRAMES uart batches of N_NUMS signed 16-bit numbers and writes them word by word to SRAM.
// A word takes at least 2 cycles (one strobe cycle plus one gap) and waits in WRITE while sram_ready is low.
module recv_store #(
  parameter int          N_NUMS    = 10,
  parameter int          N_FRAMES  = 4,
  parameter logic [20:0] BASE_ADDR = 21'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_recv,
  input  logic                  rx_available,
  input  logic [N_NUMS*16-1:0]  rx_nums,
  input  logic                  sram_ready,
  output logic                  write_data,
  output logic [20:0]           sram_addr,
  output logic [15:0]           data_out,
  output logic                  busy,
  output logic                  recv_done,
  output logic                  overrun
);

  localparam int IDX_W = $clog2(N_NUMS + 1);
  localparam int FR_W  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, WRITE, HOLD, DONE} state_t;

  state_t               state;
  logic [N_NUMS*16-1:0] rx_buf;
  logic [IDX_W-1:0]     idx;
  logic [FR_W-1:0]      frame;
  logic [20:0]          addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_buf     <= '0;
      idx        <= '0;
      frame      <= '0;
      addr       <= BASE_ADDR;
      write_data <= 1'b0;
      sram_addr  <= BASE_ADDR;
      data_out   <= 16'h0;
      busy       <= 1'b0;
      recv_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      write_data <= 1'b0;
      recv_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_recv) begin
            state   <= ARMED;
            busy    <= 1'b1;
            overrun <= 1'b0;
            frame   <= '0;
            addr    <= BASE_ADDR;
          end
        end
        ARMED: begin
          if (rx_available) begin
            rx_buf <= rx_nums;
            idx    <= '0;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (rx_available) overrun <= 1'b1;
          if (sram_ready) begin
            // The buffer shifts down so the next word is always in the low 16 bits.
            write_data <= 1'b1;
            data_out   <= rx_buf[15:0];
            rx_buf     <= rx_buf >> 16;
            sram_addr  <= addr;
            addr       <= addr + 21'd1;
            idx        <= idx + IDX_W'(1);
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (rx_available) overrun <= 1'b1;
          if (idx != IDX_W'(N_NUMS)) begin
            state <= WRITE;
          end else if (frame != FR_W'(N_FRAMES - 1)) begin
            frame <= frame + FR_W'(1);
            state <= ARMED;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          recv_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recv_store.sv
// Bench for recv_store: unit 0 is single-frame with a wrapping base, unit 1 is four frames at 0x100.
module tb_recv_store;
  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset        [2];
  logic           start_recv   [2];
  logic           rx_available [2];
  logic [N*16-1:0] rx_nums     [2];
  logic           sram_ready   [2];
  logic           write_data   [2];
  logic [20:0]    sram_addr    [2];
  logic [15:0]    data_out     [2];
  logic           busy         [2];
  logic           recv_done    [2];
  logic           overrun      [2];

  recv_store #(.N_NUMS(N), .N_FRAMES(1), .BASE_ADDR(21'h1FFFFC)) u0 (
    .clk(clk), .reset(reset[0]), .start_recv(start_recv[0]), .rx_available(rx_available[0]),
    .rx_nums(rx_nums[0]), .sram_ready(sram_ready[0]), .write_data(write_data[0]),
    .sram_addr(sram_addr[0]), .data_out(data_out[0]), .busy(busy[0]),
    .recv_done(recv_done[0]), .overrun(overrun[0]));

  recv_store #(.N_NUMS(N), .N_FRAMES(4), .BASE_ADDR(21'h100)) u1 (
    .clk(clk), .reset(reset[1]), .start_recv(start_recv[1]), .rx_available(rx_available[1]),
    .rx_nums(rx_nums[1]), .sram_ready(sram_ready[1]), .write_data(write_data[1]),
    .sram_addr(sram_addr[1]), .data_out(data_out[1]), .busy(busy[1]),
    .recv_done(recv_done[1]), .overrun(overrun[1]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt   [2];
  int done_cnt [2];
  int last_wr  [2];
  int done_at  [2];
  logic prev_wd [2];
  logic [36:0] exp0 [$];
  logic [36:0] exp1 [$];

  function automatic logic [20:0] base(input int u);
    return (u == 0) ? 21'h1FFFFC : 21'h100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every clock step goes through here so strobes are always scored.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (write_data[u]) begin
        logic [36:0] e;
        int sz;
        sz = (u == 0) ? exp0.size() : exp1.size();
        chk($sformatf("sb_expected_u%0d", u), 64'(sz != 0), 64'd1);
        if (sz != 0) begin
          if (u == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          chk($sformatf("addr_u%0d", u), 64'(sram_addr[u]), 64'(e[36:16]));
          chk($sformatf("data_u%0d", u), 64'(data_out[u]), 64'(e[15:0]));
        end
        chk($sformatf("spacing_u%0d", u), 64'(prev_wd[u]), 64'd0);
        wr_cnt[u]++;
        last_wr[u] = cyc;
      end
      if (recv_done[u]) begin
        done_cnt[u]++;
        done_at[u] = cyc;
      end
      prev_wd[u] = write_data[u];
    end
  endtask

  task automatic push(input int u, input logic [20:0] a, input logic [15:0] d);
    if (u == 0) exp0.push_back({a, d});
    else        exp1.push_back({a, d});
  endtask

  task automatic pulse_start(input int u);
    start_recv[u] = 1'b1;
    tick();
    start_recv[u] = 1'b0;
  endtask

  task automatic send_batch(input int u, input logic [20:0] a0, input logic [15:0] seed, input bit neg);
    for (int k = 0; k < N; k++) begin
      logic [15:0] v;
      v = seed + 16'(k);
      if (neg && k == N - 1) v = 16'h8000 | seed;
      rx_nums[u][k*16 +: 16] = v;
      push(u, a0 + 21'(k), v);
    end
    rx_available[u] = 1'b1;
    tick();
    rx_available[u] = 1'b0;
  endtask

  task automatic wait_wr(input int u, input int n, input int limit);
    int t = 0;
    while (wr_cnt[u] < n && t < limit) begin
      tick();
      t++;
    end
    chk($sformatf("wait_wr_u%0d", u), 64'(wr_cnt[u] >= n), 64'd1);
  endtask

  task automatic wait_done(input int u, input int limit);
    int t = 0;
    int d0 = done_cnt[u];
    while (done_cnt[u] == d0 && t < limit) begin
      tick();
      t++;
    end
    chk($sformatf("wait_done_u%0d", u), 64'(done_cnt[u] > d0), 64'd1);
  endtask

  // Sends one batch, waits out its writes, then steps past HOLD into ARMED/DONE.
  task automatic run_frame(input int u, input logic [20:0] a0, input logic [15:0] seed, input bit neg);
    int tgt = wr_cnt[u] + N;
    send_batch(u, a0, seed, neg);
    wait_wr(u, tgt, 200);
    tick();
  endtask

  task automatic chk_reset(input int u);
    chk($sformatf("rst_wd_u%0d", u),   64'(write_data[u]), 64'd0);
    chk($sformatf("rst_addr_u%0d", u), 64'(sram_addr[u]), 64'(base(u)));
    chk($sformatf("rst_data_u%0d", u), 64'(data_out[u]), 64'd0);
    chk($sformatf("rst_busy_u%0d", u), 64'(busy[u]), 64'd0);
    chk($sformatf("rst_done_u%0d", u), 64'(recv_done[u]), 64'd0);
    chk($sformatf("rst_ovr_u%0d", u),  64'(overrun[u]), 64'd0);
  endtask

  initial begin
    int b;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; start_recv[u] = 1'b0; rx_available[u] = 1'b0;
      rx_nums[u] = '0; sram_ready[u] = 1'b1;
      wr_cnt[u] = 0; done_cnt[u] = 0; last_wr[u] = 0; done_at[u] = 0; prev_wd[u] = 1'b0;
    end
    repeat (3) tick();
    chk_reset(0);
    chk_reset(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();

    // Single frame with wrapping addresses; a start_recv while busy is ignored.
    pulse_start(0);
    chk("busy_armed", 64'(busy[0]), 64'd1);
    send_batch(0, 21'h1FFFFC, 16'h1000, 1'b0);
    wait_wr(0, 3, 50);
    pulse_start(0);
    wait_wr(0, 10, 100);
    wait_done(0, 50);
    chk("done_latency", 64'(done_at[0] - last_wr[0]), 64'd2);
    chk("busy_after_done", 64'(busy[0]), 64'd0);
    chk("u0_words", 64'(wr_cnt[0]), 64'd10);
    chk("u0_sb_empty", 64'(exp0.size()), 64'd0);
    tick();
    chk("done_one_cycle", 64'(recv_done[0]), 64'd0);

    // rx_available while IDLE: no write, no overrun.
    rx_nums[0] = {N{16'hDEAD}};
    rx_available[0] = 1'b1;
    tick();
    rx_available[0] = 1'b0;
    repeat (4) tick();
    chk("idle_rx_no_ovr", 64'(overrun[0]), 64'd0);
    chk("idle_rx_no_wr", 64'(wr_cnt[0]), 64'd10);

    // Stall: ready drops in the HOLD after word 3 and stays low for 7 cycles.
    pulse_start(0);
    send_batch(0, 21'h1FFFFC, 16'h2000, 1'b0);
    wait_wr(0, 13, 50);
    sram_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_quiet", 64'(write_data[0]), 64'd0);
    end
    sram_ready[0] = 1'b1;
    wait_wr(0, 20, 100);
    wait_done(0, 50);
    chk("stall_words", 64'(wr_cnt[0]), 64'd20);
    chk("stall_sb_empty", 64'(exp0.size()), 64'd0);

    // Four frames at 0x100, each with a negative word.
    pulse_start(1);
    for (int f = 0; f < 4; f++)
      run_frame(1, 21'h100 + 21'(f * N), 16'(f * 16), 1'b1);
    wait_done(1, 50);
    repeat (4) tick();
    chk("mf_done_once", 64'(done_cnt[1]), 64'd1);
    chk("mf_words", 64'(wr_cnt[1]), 64'd40);
    chk("mf_no_ovr", 64'(overrun[1]), 64'd0);
    chk("mf_sb_empty", 64'(exp1.size()), 64'd0);

    // Overrun during word 5: first batch completes, second dropped.
    pulse_start(1);
    b = wr_cnt[1];
    send_batch(1, 21'h100, 16'h3000, 1'b0);
    wait_wr(1, b + 5, 50);
    rx_nums[1] = {N{16'hBEEF}};
    rx_available[1] = 1'b1;
    tick();
    rx_available[1] = 1'b0;
    chk("ovr_set", 64'(overrun[1]), 64'd1);
    wait_wr(1, b + 10, 50);
    tick();
    chk("ovr_armed_busy", 64'(busy[1]), 64'd1);
    for (int f = 1; f < 4; f++)
      run_frame(1, 21'h100 + 21'(f * N), 16'h3100 + 16'(f * 16), 1'b0);
    wait_done(1, 50);
    chk("ovr_sticky", 64'(overrun[1]), 64'd1);
    pulse_start(1);
    chk("ovr_cleared", 64'(overrun[1]), 64'd0);

    // rx_available on the HOLD edge that returns to ARMED is an overrun, not a capture.
    b = wr_cnt[1];
    send_batch(1, 21'h100, 16'h4000, 1'b0);
    wait_wr(1, b + 10, 50);
    rx_nums[1] = {N{16'h5A5A}};
    rx_available[1] = 1'b1;
    tick();
    rx_available[1] = 1'b0;
    repeat (4) tick();
    chk("hold_edge_ovr", 64'(overrun[1]), 64'd1);
    chk("hold_edge_no_wr", 64'(wr_cnt[1]), 64'(b + 10));

    // Reset while in WRITE before the fifth word of the next frame.
    b = wr_cnt[1];
    send_batch(1, 21'h10A, 16'h6000, 1'b0);
    wait_wr(1, b + 4, 50);
    tick();
    reset[1] = 1'b1;
    tick();
    chk_reset(1);
    reset[1] = 1'b0;
    exp1.delete();
    tick();
    chk("rst_no_wr", 64'(wr_cnt[1]), 64'(b + 4));
    pulse_start(1);
    for (int f = 0; f < 4; f++)
      run_frame(1, 21'h100 + 21'(f * N), 16'h7000 + 16'(f * 16), 1'b0);
    wait_done(1, 50);
    chk("restart_sb_empty", 64'(exp1.size()), 64'd0);
    chk("restart_no_ovr", 64'(overrun[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
